// File: rtl/fb_arb_pkg.sv
// fb_arb_pkg -- shared constants and the grant-kind enum for the frame-buffer
// RAM arbiter (fb_mem_arbiter) and its prefetch FIFO.
//   ADDR_W      : RAM word-address width
//   DATA_W      : RAM word width (four 8-bit palette indices)
//   FRAME_WORDS : words per 640x480 frame
//   grant_t     : what the single RAM port does in a given cycle
package fb_arb_pkg;

    localparam int ADDR_W      = 19;
    localparam int DATA_W      = 32;
    localparam int FRAME_WORDS = 76800;
    localparam int FIFO_DEPTH  = 4;
    localparam int LOW_WATER   = 2;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_DISP,
        GNT_HOST_RD,
        GNT_HOST_WR
    } grant_t;

endpackage

// File: rtl/fb_mem_arbiter_fifo.sv
// fb_prefetch_fifo -- small synchronous FIFO that buffers display words read
// ahead of the VGA pixel pipeline.
// Ports:
//   clk_i, rst_n_i        clock, asynchronous active-low reset
//   flush_i               empty the FIFO and clear the underrun flag (wins
//                         over a push or pop in the same cycle)
//   push_i, push_data_i   write one word at the tail
//   pop_i                 consume the head word (ignored when empty)
//   data_o, valid_o       head word (0 when empty) and non-empty flag
//   count_o               number of stored words, 0..DEPTH
//   underrun_o            sticky: a pop arrived while empty
module fb_prefetch_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic [DATA_W-1:0]          push_data_i,
    input  logic                       pop_i,
    output logic [DATA_W-1:0]          data_o,
    output logic                       valid_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       underrun_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [PTR_W:0]    count_q;
    logic              underrun_q;
    logic              empty;
    logic              do_pop;

    assign empty  = (count_q == '0);
    assign do_pop = pop_i && !empty;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            underrun_q <= 1'b0;
        end else if (flush_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            underrun_q <= 1'b0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push_i, do_pop})
                2'b10:   count_q <= count_q + (PTR_W+1)'(1);
                2'b01:   count_q <= count_q - (PTR_W+1)'(1);
                default: count_q <= count_q;
            endcase
            if (pop_i && empty) underrun_q <= 1'b1;
        end
    end

    // NOTE: the storage array has no reset; only pointers and count do, and
    // the head word is masked while empty so stale contents never leak out.
    always_ff @(posedge clk_i) begin
        if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign data_o     = empty ? '0 : mem_q[rd_ptr_q];
    assign valid_o    = !empty;
    assign count_o    = count_q;
    assign underrun_o = underrun_q;

endmodule

// File: rtl/fb_mem_arbiter.sv
// fb_mem_arbiter -- shares one single-port frame-buffer RAM between the VGA
// scan-out prefetch FIFO and a host req/ack port, one RAM access per clock.
// Ports:
//   iCLK, iRST_n                 clock, asynchronous active-low reset
//   iDISP_START                  frame start: restart display address, flush FIFO
//   iDISP_POP                    display consumes the head word
//   oDISP_DATA/VALID/UNDERRUN    FIFO head, non-empty, sticky underrun
//   iHOST_REQ/WE/ADDR/WD         host request (held stable until oHOST_ACK)
//   oHOST_ACK, oHOST_RD          completion pulse and read data
//   oRAM_WE/ADDR/WD, iRAM_RD     RAM port (read data one cycle after address)
//   oSTALL_CNT                   host stall counter
// Optional feature: define FB_ARB_STATS_EN to build the stall counter;
// otherwise oSTALL_CNT is tied to 0.
module fb_mem_arbiter
    import fb_arb_pkg::*;
#(
    parameter int ADDR_W      = fb_arb_pkg::ADDR_W,
    parameter int DATA_W      = fb_arb_pkg::DATA_W,
    parameter int FRAME_WORDS = fb_arb_pkg::FRAME_WORDS,
    parameter int FIFO_DEPTH  = fb_arb_pkg::FIFO_DEPTH,
    parameter int LOW_WATER   = fb_arb_pkg::LOW_WATER
) (
    input  logic              iCLK,
    input  logic              iRST_n,
    input  logic              iDISP_START,
    input  logic              iDISP_POP,
    output logic [DATA_W-1:0] oDISP_DATA,
    output logic              oDISP_VALID,
    output logic              oDISP_UNDERRUN,
    input  logic              iHOST_REQ,
    input  logic              iHOST_WE,
    input  logic [ADDR_W-1:0] iHOST_ADDR,
    input  logic [DATA_W-1:0] iHOST_WD,
    output logic              oHOST_ACK,
    output logic [DATA_W-1:0] oHOST_RD,
    output logic              oRAM_WE,
    output logic [ADDR_W-1:0] oRAM_ADDR,
    output logic [DATA_W-1:0] oRAM_WD,
    input  logic [DATA_W-1:0] iRAM_RD,
    output logic [15:0]       oSTALL_CNT
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    grant_t            grant;
    grant_t            tag_q;       // kind of the access whose data returns this cycle
    logic [ADDR_W-1:0] disp_addr_q;
    logic [ADDR_W-1:0] ram_addr_q;  // last driven address, held on idle cycles
    logic [DATA_W-1:0] host_rd_q;
    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W:0]    eff_level;
    logic              disp_in_flight;
    logic              host_in_flight;
    logic              disp_avail;
    logic              host_elig;

    assign disp_in_flight = (tag_q == GNT_DISP);
    // The host access is in flight exactly in its ack cycle.
    assign host_in_flight = (tag_q == GNT_HOST_RD) || (tag_q == GNT_HOST_WR);
    assign eff_level      = {1'b0, fifo_count} + {{CNT_W{1'b0}}, disp_in_flight};
    // No display read in the START cycle: its address is about to be reset.
    assign disp_avail     = (disp_addr_q < ADDR_W'(FRAME_WORDS)) && !iDISP_START;
    assign host_elig      = iHOST_REQ && !host_in_flight;

    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        grant = GNT_NONE;
        if (disp_avail && (eff_level < (CNT_W+1)'(LOW_WATER))) begin
            grant = GNT_DISP;
        end else if (host_elig) begin
            grant = iHOST_WE ? GNT_HOST_WR : GNT_HOST_RD;
        end else if (disp_avail && (eff_level < (CNT_W+1)'(FIFO_DEPTH))) begin
            grant = GNT_DISP;
        end
    end

    always_comb begin
        oRAM_WE   = 1'b0;
        oRAM_ADDR = ram_addr_q;
        oRAM_WD   = '0;
        case (grant)
            GNT_DISP:    oRAM_ADDR = disp_addr_q;
            GNT_HOST_RD: oRAM_ADDR = iHOST_ADDR;
            GNT_HOST_WR: begin
                oRAM_WE   = 1'b1;
                oRAM_ADDR = iHOST_ADDR;
                oRAM_WD   = iHOST_WD;
            end
            default: ;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            tag_q       <= GNT_NONE;
            disp_addr_q <= '0;
            ram_addr_q  <= '0;
            host_rd_q   <= '0;
        end else begin
            tag_q      <= grant;
            ram_addr_q <= oRAM_ADDR;
            if (iDISP_START) begin
                disp_addr_q <= '0;
            end else if (grant == GNT_DISP) begin
                disp_addr_q <= disp_addr_q + ADDR_W'(1);
            end
            if (tag_q == GNT_HOST_RD) host_rd_q <= iRAM_RD;
        end
    end

    assign oHOST_ACK = host_in_flight;
    assign oHOST_RD  = (tag_q == GNT_HOST_RD) ? iRAM_RD : host_rd_q;

    // A display word returning in the START cycle is dropped because the
    // flush overrides the push inside the FIFO.
    fb_prefetch_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk_i       (iCLK),
        .rst_n_i     (iRST_n),
        .flush_i     (iDISP_START),
        .push_i      (disp_in_flight),
        .push_data_i (iRAM_RD),
        .pop_i       (iDISP_POP),
        .data_o      (oDISP_DATA),
        .valid_o     (oDISP_VALID),
        .count_o     (fifo_count),
        .underrun_o  (oDISP_UNDERRUN)
    );

`ifdef FB_ARB_STATS_EN
    logic [15:0] stall_q;
    logic        host_gnt;

    assign host_gnt = (grant == GNT_HOST_RD) || (grant == GNT_HOST_WR);

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            stall_q <= '0;
        end else if (iDISP_START) begin
            stall_q <= '0;
        end else if (iHOST_REQ && !host_gnt && !host_in_flight && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign oSTALL_CNT = stall_q;
`else
    assign oSTALL_CNT = 16'd0;
`endif

endmodule

// File: tb/tb_fb_mem_arbiter.sv
// tb_fb_mem_arbiter -- directed stimulus for fb_mem_arbiter with a queue-based
// reference model checked every cycle, plus hand-computed literal checks.
// Build with FB_ARB_STATS_EN defined to also check the stall counter.
module tb_fb_mem_arbiter;

    localparam int ADDR_W      = 19;
    localparam int DATA_W      = 32;
    localparam int FRAME_WORDS = 76800;
    localparam int FIFO_DEPTH  = 4;
    localparam int LOW_WATER   = 2;
    localparam int MEM_WORDS   = 1 << ADDR_W;

    localparam int K_NONE = 0;
    localparam int K_DISP = 1;
    localparam int K_RD   = 2;
    localparam int K_WR   = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              disp_start, disp_pop;
    logic [DATA_W-1:0] disp_data;
    logic              disp_valid, disp_underrun;
    logic              host_req, host_we;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wd;
    logic              host_ack;
    logic [DATA_W-1:0] host_rd;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wd;
    logic [DATA_W-1:0] ram_rd;
    logic [15:0]       stall_cnt;

    always #5 clk = ~clk;

    fb_mem_arbiter dut (
        .iCLK           (clk),
        .iRST_n         (rst_n),
        .iDISP_START    (disp_start),
        .iDISP_POP      (disp_pop),
        .oDISP_DATA     (disp_data),
        .oDISP_VALID    (disp_valid),
        .oDISP_UNDERRUN (disp_underrun),
        .iHOST_REQ      (host_req),
        .iHOST_WE       (host_we),
        .iHOST_ADDR     (host_addr),
        .iHOST_WD       (host_wd),
        .oHOST_ACK      (host_ack),
        .oHOST_RD       (host_rd),
        .oRAM_WE        (ram_we),
        .oRAM_ADDR      (ram_addr),
        .oRAM_WD        (ram_wd),
        .iRAM_RD        (ram_rd),
        .oSTALL_CNT     (stall_cnt)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // RAM: word[n] = n initially, one-cycle read latency, read-before-write.
    logic [DATA_W-1:0] ram_mem [MEM_WORDS];
    initial begin
        for (int i = 0; i < MEM_WORDS; i++) ram_mem[i] = DATA_W'(i);
        ram_rd = '0;
        forever begin
            @(posedge clk);
            ram_rd <= ram_mem[ram_addr];
            if (ram_we) ram_mem[ram_addr] <= ram_wd;
        end
    end

    // Reference model: FIFO as a queue, display pointer, one in-flight record.
    logic [DATA_W-1:0] m_mem [MEM_WORDS];
    logic [DATA_W-1:0] m_q [$];
    int                m_daddr, m_fl, m_last_addr, m_stall;
    logic [DATA_W-1:0] m_fl_data, m_last_rd;
    logic              m_under;

    task automatic model_reset();
        m_q.delete();
        m_daddr = 0; m_fl = K_NONE; m_last_addr = 0; m_stall = 0;
        m_fl_data = '0; m_last_rd = '0; m_under = 1'b0;
    endtask

    initial begin
        int lvl, g, e_addr;
        logic e_ack;
        logic [DATA_W-1:0] e_hrd;
        for (int i = 0; i < MEM_WORDS; i++) m_mem[i] = DATA_W'(i);
        model_reset();
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                model_reset();
            end else begin
                e_ack = (m_fl == K_RD) || (m_fl == K_WR);
                e_hrd = (m_fl == K_RD) ? m_fl_data : m_last_rd;
                lvl   = m_q.size() + ((m_fl == K_DISP) ? 1 : 0);
                if (m_daddr < FRAME_WORDS && !disp_start && lvl < LOW_WATER) g = K_DISP;
                else if (host_req && !e_ack) g = host_we ? K_WR : K_RD;
                else if (m_daddr < FRAME_WORDS && !disp_start && lvl < FIFO_DEPTH) g = K_DISP;
                else g = K_NONE;
                e_addr = (g == K_DISP) ? m_daddr : (g == K_NONE) ? m_last_addr : int'(host_addr);

                check("m_ram_we", 64'(ram_we), 64'(g == K_WR));
                check("m_ram_addr", 64'(ram_addr), 64'(e_addr));
                if (g == K_WR) check("m_ram_wd", 64'(ram_wd), 64'(host_wd));
                check("m_ack", 64'(host_ack), 64'(e_ack));
                check("m_host_rd", 64'(host_rd), 64'(e_hrd));
                check("m_valid", 64'(disp_valid), 64'(m_q.size() != 0));
                if (m_q.size() != 0) check("m_disp_data", 64'(disp_data), 64'(m_q[0]));
                check("m_underrun", 64'(disp_underrun), 64'(m_under));
`ifdef FB_ARB_STATS_EN
                check("m_stall", 64'(stall_cnt), 64'(m_stall));
`else
                check("m_stall", 64'(stall_cnt), 64'd0);
`endif
                // advance to the state after the coming clock edge
                if (m_fl == K_RD) m_last_rd = m_fl_data;
                if (disp_start) begin
                    m_q.delete();
                    m_under = 1'b0;
                    m_daddr = 0;
                    m_stall = 0;
                end else begin
                    if (disp_pop) begin
                        if (m_q.size() == 0) m_under = 1'b1;
                        else void'(m_q.pop_front());
                    end
                    if (m_fl == K_DISP) m_q.push_back(m_fl_data);
                    if (host_req && g != K_RD && g != K_WR && !e_ack && m_stall < 65535)
                        m_stall++;
                end
                m_fl_data = (g == K_DISP || g == K_RD) ? m_mem[e_addr] : '0;
                if (g == K_WR) m_mem[e_addr] = host_wd;
                if (g == K_DISP) m_daddr++;
                m_fl = g;
                m_last_addr = e_addr;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acks, pops;
        logic [DATA_W-1:0] last_word;
        rst_n = 1'b0; disp_start = 1'b0; disp_pop = 1'b0;
        host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wd = '0;
        repeat (3) tick();
        #1;
        check("rst_valid", 64'(disp_valid), 64'd0);
        check("rst_ack", 64'(host_ack), 64'd0);
        check("rst_underrun", 64'(disp_underrun), 64'd0);
        check("rst_ram_we", 64'(ram_we), 64'd0);
        check("rst_host_rd", 64'(host_rd), 64'd0);
        check("rst_stall", 64'(stall_cnt), 64'd0);

        // Prefetch after reset: addresses 0..3, valid two cycles after release.
        tick(); rst_n = 1'b1; #1;
        check("disp_addr0", 64'(ram_addr), 64'd0);
        tick(); #1;
        check("disp_addr1", 64'(ram_addr), 64'd1);
        check("valid_c1", 64'(disp_valid), 64'd0);
        tick(); #1;
        check("disp_addr2", 64'(ram_addr), 64'd2);
        check("valid_c2", 64'(disp_valid), 64'd1);
        tick(); #1;
        check("disp_addr3", 64'(ram_addr), 64'd3);
        tick(); tick(); #1;
        for (int i = 0; i < 4; i++) begin
            check("pop_data", 64'(disp_data), 64'(i));
            disp_pop = 1'b1;
            tick(); #1;
        end
        disp_pop = 1'b0;
        repeat (6) tick();

        // Host write then read of 0x100 with the FIFO full.
        host_req = 1'b1; host_we = 1'b1; host_addr = 19'h100; host_wd = 32'hDEADBEEF; #1;
        check("hw_we", 64'(ram_we), 64'd1);
        check("hw_addr", 64'(ram_addr), 64'h100);
        check("hw_wd", 64'(ram_wd), 64'hDEADBEEF);
        tick(); #1;
        check("hw_ack", 64'(host_ack), 64'd1);
        check("hw_ack_cycle_we", 64'(ram_we), 64'd0);
        tick(); host_req = 1'b0; #1;
        check("hw_single_ack", 64'(host_ack), 64'd0);
        host_req = 1'b1; host_we = 1'b0; #1;
        check("hr_addr", 64'(ram_addr), 64'h100);
        tick(); #1;
        check("hr_ack", 64'(host_ack), 64'd1);
        check("hr_data", 64'(host_rd), 64'hDEADBEEF);
        tick(); host_req = 1'b0; #1;
        check("hr_single_ack", 64'(host_ack), 64'd0);

        // Display drains whenever data is present while the host keeps requesting.
        host_req = 1'b1; host_we = 1'b0; host_addr = 19'd5;
        acks = 0;
        tick();
        for (int i = 0; i < 40; i++) begin
            disp_pop = disp_valid;
            if (host_ack) acks++;
            tick();
        end
        disp_pop = 1'b0; host_req = 1'b0;
        check("mix_host_served", 64'(acks != 0), 64'd1);
        check("mix_no_underrun", 64'(disp_underrun), 64'd0);
`ifdef FB_ARB_STATS_EN
        check("mix_stall_nonzero", 64'(stall_cnt != 0), 64'd1);
`endif
        repeat (6) tick();

        // Underrun: pop right after a flush, flag sticky, START clears it.
        disp_start = 1'b1;
        tick(); disp_start = 1'b0; disp_pop = 1'b1; #1;
        check("start_addr0", 64'(ram_addr), 64'd0);
        check("start_empty", 64'(disp_valid), 64'd0);
        tick(); disp_pop = 1'b0; #1;
        check("underrun_set", 64'(disp_underrun), 64'd1);
        repeat (3) tick();
        #1;
        check("underrun_sticky", 64'(disp_underrun), 64'd1);
        tick(); disp_start = 1'b1;
        tick(); disp_start = 1'b0; #1;
        check("underrun_cleared", 64'(disp_underrun), 64'd0);
        check("restart_addr0", 64'(ram_addr), 64'd0);

        // START while a display read is in flight; host read granted alongside.
        tick(); disp_start = 1'b1; host_req = 1'b1; host_we = 1'b0; host_addr = 19'h100; #1;
        check("start_host_addr", 64'(ram_addr), 64'h100);
        tick(); disp_start = 1'b0; #1;
        check("start_host_ack", 64'(host_ack), 64'd1);
        check("start_host_data", 64'(host_rd), 64'hDEADBEEF);
        check("start_disp_dropped", 64'(disp_valid), 64'd0);
        tick(); host_req = 1'b0; #1;
        check("start_still_empty", 64'(disp_valid), 64'd0);
        repeat (6) tick();

        // Reset during a host read's return cycle: no ack afterwards.
        host_req = 1'b1; host_we = 1'b0; host_addr = 19'h200;
        tick(); rst_n = 1'b0; host_req = 1'b0; #1;
        check("rst_kills_ack", 64'(host_ack), 64'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        acks = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (host_ack) acks++;
        end
        check("rst_no_late_ack", 64'(acks), 64'd0);

        // Whole frame: display address stops at the last word until START.
        pops = 0; last_word = '0;
        for (int i = 0; i < 80000; i++) begin
            tick();
            disp_pop = disp_valid;
            if (disp_valid) begin
                pops++;
                last_word = disp_data;
            end
            if (pops == FRAME_WORDS) break;
        end
        tick(); disp_pop = 1'b0;
        repeat (5) tick();
        #1;
        check("frame_pops", 64'(pops), 64'(FRAME_WORDS));
        check("frame_last_word", 64'(last_word), 64'(FRAME_WORDS - 1));
        check("frame_end_empty", 64'(disp_valid), 64'd0);
        check("frame_last_addr", 64'(ram_addr), 64'(FRAME_WORDS - 1));
        disp_start = 1'b1;
        tick(); disp_start = 1'b0; #1;
        check("frame_restart_addr0", 64'(ram_addr), 64'd0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
